ram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of the dual-port 2KB RAM (11-bit address, 8-bit data) among NUM_REQ requesters, e.g. CPU, DMA, debug.
- Accepts one request per grant, registers it, and drives the RAM port for exactly one cycle.
- Returns a per-requester completion pulse, carrying read data for reads.
- Sits between the requesters and either RAM port (A or B); one instance per port.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/ram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// The lock feature of ram_port_arbiter is enabled by defining RAM_ARB_LOCK_EN.
package ram_arb_pkg;

  localparam int RAM_ADDR_W       = 11;
  localparam int RAM_DATA_W       = 8;
  localparam int RAM_ARB_MAX_LOCK = 4;
  localparam int RAM_ARB_ID_W     = 3;  // enough for up to 8 requesters
  localparam int RAM_ARB_LOCK_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [RAM_ARB_ID_W-1:0] id;
    logic                    we;
    logic [RAM_ADDR_W-1:0]   addr;
    logic [RAM_DATA_W-1:0]   data;
  } ram_cmd_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr_i,
// wrapping modulo N. Returns one-hot grant, encoded index and a found flag.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  int   slot;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    slot    = 0;
    // k is the search distance from the pointer; the nearest valid slot wins
    for (int k = 0; k < N; k++) begin
      slot = int'(ptr_i) + k;
      if (slot >= N) slot = slot - N;
      for (int i = 0; i < N; i++) begin
        if (!found && valid_i[i] && (i == slot)) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = ID_W'(i);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
// Optional burst lock (up to RAM_ARB_MAX_LOCK grants) when RAM_ARB_LOCK_EN is defined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_wr_en,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rd_data
);

  localparam int ID_W = RAM_ARB_ID_W;

  arb_state_t          state_q, state_d;
  ram_cmd_t            cmd_q, cmd_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [ID_W-1:0]     adv_ptr;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef RAM_ARB_LOCK_EN
  logic [RAM_ARB_LOCK_W-1:0] lock_cnt_q, lock_cnt_d, lock_next;
  logic                      sel_lock;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  rr_priority_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign adv_ptr = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

  // Only the winner's fields are muxed in, selected by the one-hot grant
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
`ifdef RAM_ARB_LOCK_EN
        sel_lock  = req_lock[i];
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    req_ready   = '0;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
`ifdef RAM_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    lock_next   = '0;
`endif
    case (state_q)
      IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          cmd_d.id   = pick_idx;
          cmd_d.we   = sel_we;
          cmd_d.addr = RAM_ADDR_W'(sel_addr);
          cmd_d.data = RAM_DATA_W'(sel_wdata);
          state_d    = ISSUE;
`ifdef RAM_ARB_LOCK_EN
          // A run continues only while the same requester keeps winning with lock set
          if (sel_lock) begin
            lock_next = (pick_idx == rr_ptr_q && lock_cnt_q != '0)
                        ? lock_cnt_q + RAM_ARB_LOCK_W'(1) : RAM_ARB_LOCK_W'(1);
            if (lock_next >= RAM_ARB_LOCK_W'(RAM_ARB_MAX_LOCK)) begin
              rr_ptr_d   = adv_ptr;
              lock_cnt_d = '0;
            end else begin
              rr_ptr_d   = pick_idx;
              lock_cnt_d = lock_next;
            end
          end else begin
            rr_ptr_d   = adv_ptr;
            lock_cnt_d = '0;
          end
`else
          rr_ptr_d = adv_ptr;
`endif
        end
      end
      ISSUE: begin
        ram_wr_en   = cmd_q.we;
        ram_rd_en   = !cmd_q.we;
        ram_addr    = ADDR_W'(cmd_q.addr);
        ram_wdata   = DATA_W'(cmd_q.data);
        rsp_valid_d = NUM_REQ'(1) << cmd_q.id;
        rsp_rdata_d = cmd_q.we ? '0 : ram_rd_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef RAM_ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a 2KB RAM model.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_wr_en, ram_rd_en;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rd_data;

  logic [DW-1:0]   mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  int fair_seq [6] = '{0, 1, 2, 3, 0, 1};
`ifdef RAM_ARB_LOCK_EN
  int lock_seq [5] = '{1, 1, 1, 1, 2};
`else
  int lock_seq [5] = '{1, 2, 1, 2, 1};
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rd_data (ram_rd_data)
  );

  always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_wdata;
  assign ram_rd_data = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = '0;
    reset = 1'b1;
    clr_all();
    repeat (2) @(posedge clk);

    // reset state
    tick(); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_ram_en", {30'b0, ram_wr_en, ram_rd_en}, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
    reset = 1'b0;

    // single write: requester 0 writes 0xA5 to 0x7FF
    tick(); set_req(0, 1'b1, 1'b1, 11'h7FF, 8'hA5); #1;
    chk("wr_ready_T", 32'(req_ready), 32'h1);
    chk("wr_idle_no_ram", {30'b0, ram_wr_en, ram_rd_en}, 32'h0);
    tick(); #1;
    chk("wr_issue_ready0", 32'(req_ready), 32'h0);
    chk("wr_issue_en", {30'b0, ram_wr_en, ram_rd_en}, 32'h2);
    chk("wr_issue_addr", 32'(ram_addr), 32'h7FF);
    chk("wr_issue_wdata", 32'(ram_wdata), 32'hA5);
    clr_all();
    tick(); #1;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("wr_mem", 32'(mem[11'h7FF]), 32'hA5);
    chk("wr_ptr", 32'(dut.rr_ptr_q), 32'h1);
    $display("txn write req0 addr=0x7ff data=0xa5 rsp_valid=%b", rsp_valid);

    // read back: requester 2 reads 0x7FF
    tick(); set_req(2, 1'b1, 1'b0, 11'h7FF, 8'h00); #1;
    chk("rd_ready_T", 32'(req_ready), 32'h4);
    tick(); #1;
    chk("rd_issue_en", {30'b0, ram_wr_en, ram_rd_en}, 32'h1);
    chk("rd_issue_addr", 32'(ram_addr), 32'h7FF);
    clr_all();
    tick(); #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd_ptr", 32'(dut.rr_ptr_q), 32'h3);
    $display("txn read req2 addr=0x7ff rdata=0x%0h", rsp_rdata);

    // wrap and skip: rr_ptr = 3, requesters 1 and 3 valid
    tick(); set_req(1, 1'b1, 1'b0, 11'h010, 8'h00); set_req(3, 1'b1, 1'b0, 11'h011, 8'h00); #1;
    chk("wrap_g0", 32'(req_ready), 32'h8);
    tick(); #1;
    chk("wrap_issue0", 32'(req_ready), 32'h0);
    tick(); #1;
    chk("wrap_g1", 32'(req_ready), 32'h2);
    chk("wrap_rsp0", 32'(rsp_valid), 32'h8);
    tick(); #1;
    tick(); #1;
    chk("wrap_g2", 32'(req_ready), 32'h8);
    chk("wrap_rsp1", 32'(rsp_valid), 32'h2);
    tick(); #1;
    clr_all();
    tick(); #1;
    chk("wrap_ptr", 32'(dut.rr_ptr_q), 32'h0);
    $display("txn wrap grants 3,1,3 done");

    // fairness: all four valid from reset
    tick(); reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 11'(32 + i), 8'(16 + i));
    tick(); reset = 1'b0; #1;
    chk("fair_state", 32'(dut.state_q), 32'h0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin tick(); #1; end
      if (c % 2 == 0) chk($sformatf("fair_grant%0d", c / 2), 32'(req_ready), 32'(1) << fair_seq[c / 2]);
      else            chk($sformatf("fair_issue%0d", c / 2), 32'(req_ready), 32'h0);
      $display("txn fair cycle=%0d ready=%b", c, req_ready);
    end
    clr_all();
    tick(); #1;

    // reset during ISSUE of a read
    tick(); set_req(0, 1'b1, 1'b0, 11'h7FF, 8'h00); #1;
    chk("rsti_ready", 32'(req_ready), 32'h1);
    tick(); #1;
    chk("rsti_issue_rd", 32'(ram_rd_en), 32'h1);
    reset = 1'b1;
    clr_all();
    tick(); reset = 1'b0; #1;
    chk("rsti_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rsti_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rsti_state", 32'(dut.state_q), 32'h0);
    chk("rsti_ptr", 32'(dut.rr_ptr_q), 32'h0);
    $display("txn reset-in-issue rsp_valid=%b", rsp_valid);

    // lock: requester 1 valid+lock, requester 2 valid
    tick(); set_req(1, 1'b1, 1'b0, 11'h040, 8'h00); req_lock[1] = 1'b1;
    set_req(2, 1'b1, 1'b0, 11'h041, 8'h00); #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin tick(); #1; end
      if (c % 2 == 0) begin
        chk($sformatf("lock_grant%0d", c / 2), 32'(req_ready), 32'(1) << lock_seq[c / 2]);
        $display("txn lock grant=%0d ready=%b", c / 2, req_ready);
      end
    end
    clr_all();
    tick(); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
